wb_regfile: RTL and testbench

- Writeback stage and architectural register file of the 5-stage RISC-V core.
- Consumes the W-stage signals produced by the memory stage: reg_wrW, result_srcW, ALU_resultW, rd_dataW, PCp4W and rdW.
- Selects the writeback result and performs load-data extraction: byte or halfword lane select plus sign or zero extension.
- Writes the result into a 32x32 register array and serves two combinational read ports to decode, with write-through bypass.

---
 rtl/wb_regfile.sv | 118 +++++++++++
 tb/tb_wb_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_regfile : writeback result select, load extraction and 32x32 register   |
// |              file with two combinational read ports and write-through.     |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module wb_regfile #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_wrW,
  input  logic [1:0]         result_srcW,
  input  logic [2:0]         funct3W,
  input  logic [XLEN-1:0]    ALU_resultW,
  input  logic [XLEN-1:0]    rd_dataW,
  input  logic [XLEN-1:0]    PCp4W,
  input  logic [RADDR_W-1:0] rdW,
  input  logic [RADDR_W-1:0] rs1D,
  input  logic [RADDR_W-1:0] rs2D,
  output logic [XLEN-1:0]    rd1D,
  output logic [XLEN-1:0]    rd2D,
  output logic [XLEN-1:0]    resultW,
  output logic               load_misalignW,
  output logic [31:0]        wb_countW
);

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;

  localparam logic [1:0] c_SRC_ALU  = 2'b00;
  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [1:0] c_SRC_PC4  = 2'b10;

  logic [XLEN-1:0] r_regs [NREGS];
  logic [31:0]     r_wb_count;

  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic            w_misalign;
  logic [XLEN-1:0] w_result;
  logic            w_we;

  assign w_off = ALU_resultW[1:0];

  always_comb begin
    w_byte = 8'h00;
    case (w_off)
      2'd0:    w_byte = rd_dataW[7:0];
      2'd1:    w_byte = rd_dataW[15:8];
      2'd2:    w_byte = rd_dataW[23:16];
      default: w_byte = rd_dataW[31:24];
    endcase
    w_half = w_off[1] ? rd_dataW[31:16] : rd_dataW[15:0];

    w_load = '0;
    case (funct3W)
      c_LB:    w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_LBU:   w_load = {{(XLEN-8){1'b0}}, w_byte};
      c_LH:    w_load = {{(XLEN-16){w_half[15]}}, w_half};
      c_LHU:   w_load = {{(XLEN-16){1'b0}}, w_half};
      c_LW:    w_load = rd_dataW;
      default: w_load = '0;
    endcase
  end

  assign w_misalign = (result_srcW == c_SRC_LOAD) &&
                      ((((funct3W == c_LH) || (funct3W == c_LHU)) && w_off[0]) ||
                       ((funct3W == c_LW) && (w_off != 2'd0)));

  always_comb begin
    w_result = '0;
    case (result_srcW)
      c_SRC_ALU:  w_result = ALU_resultW;
      c_SRC_LOAD: w_result = w_load;
      c_SRC_PC4:  w_result = PCp4W;
      default:    w_result = '0;
    endcase
  end

  assign w_we = reg_wrW && (rdW != '0) && !w_misalign;

  // Read port: x0 reads zero, a same-cycle write to the same index is bypassed.
  function automatic logic [XLEN-1:0] read_port(input logic [RADDR_W-1:0] rs);
    if (rs == '0)
      return '0;
    else if (w_we && (rs == rdW))
      return w_result;
    else
      return r_regs[rs];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
      r_wb_count <= '0;
    end else if (w_we) begin
      r_regs[rdW] <= w_result;
      r_wb_count  <= r_wb_count + 32'd1;
    end
  end

  assign rd1D           = read_port(rs1D);
  assign rd2D           = read_port(rs2D);
  assign resultW        = w_result;
  assign load_misalignW = w_misalign;
  assign wb_countW      = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_regfile : directed self-checking bench for wb_regfile.               |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        reg_wrW;
  logic [1:0]  result_srcW;
  logic [2:0]  funct3W;
  logic [31:0] ALU_resultW;
  logic [31:0] rd_dataW;
  logic [31:0] PCp4W;
  logic [4:0]  rdW;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [31:0] rd1D;
  logic [31:0] rd2D;
  logic [31:0] resultW;
  logic        load_misalignW;
  logic [31:0] wb_countW;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  wb_regfile #(.XLEN(32), .NREGS(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wrW(reg_wrW), .result_srcW(result_srcW),
    .funct3W(funct3W), .ALU_resultW(ALU_resultW), .rd_dataW(rd_dataW),
    .PCp4W(PCp4W), .rdW(rdW), .rs1D(rs1D), .rs2D(rs2D), .rd1D(rd1D),
    .rd2D(rd2D), .resultW(resultW), .load_misalignW(load_misalignW),
    .wb_countW(wb_countW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reg_wrW = 0; result_srcW = 2'b00; funct3W = 3'b010; ALU_resultW = 0;
    rd_dataW = 0; PCp4W = 0; rdW = 0;
  endtask

  // Drive an ALU write at a negedge and let it land on the next posedge.
  task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    idle();
    reg_wrW = 1; rdW = rd; ALU_resultW = val;
    @(posedge clk); #1;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); rs1D = 5; rs2D = 0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (rd1D !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want %h", rd1D, 32'h0); end
    checks++; if (wb_countW !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h want %h", wb_countW, 32'h0); end
    rst_n = 1;
    alu_write(5, 32'h12345678);
    #1;
    checks++; if (rd1D !== 32'h12345678) begin errors++; $display("FAIL x5_written got %h want %h", rd1D, 32'h12345678); end
    checks++; if (wb_countW !== 32'd1) begin errors++; $display("FAIL x5_cnt got %h want %h", wb_countW, 32'd1); end
    #2 rst_n = 0;
    #1;
    checks++; if (rd1D !== 32'h0) begin errors++; $display("FAIL async_rst_rd1 got %h want %h", rd1D, 32'h0); end
    checks++; if (wb_countW !== 32'h0) begin errors++; $display("FAIL async_rst_cnt got %h want %h", wb_countW, 32'h0); end
    // write attempted while reset is held must be discarded
    @(negedge clk);
    reg_wrW = 1; rdW = 5; ALU_resultW = 32'hAAAA5555;
    @(posedge clk); #1;
    @(negedge clk);
    idle(); #1;
    checks++; if (rd1D !== 32'h0) begin errors++; $display("FAIL rst_mid_write got %h want %h", rd1D, 32'h0); end
    checks++; if (wb_countW !== 32'h0) begin errors++; $display("FAIL rst_mid_cnt got %h want %h", wb_countW, 32'h0); end
    rst_n = 1;
    alu_write(5, 32'h0000A5A5);
    #1;
    checks++; if (rd1D !== 32'h0000A5A5) begin errors++; $display("FAIL post_rst_write got %h want %h", rd1D, 32'h0000A5A5); end
    exp_cnt = 32'd1;
    checks++; if (wb_countW !== exp_cnt) begin errors++; $display("FAIL post_rst_cnt got %h want %h", wb_countW, exp_cnt); end
  endtask

  task automatic test_alu_bypass();
    @(negedge clk);
    idle();
    reg_wrW = 1; rdW = 7; ALU_resultW = 32'hDEADBEEF; rs1D = 7; rs2D = 7;
    #1;
    checks++; if (rd1D !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1 got %h want %h", rd1D, 32'hDEADBEEF); end
    checks++; if (rd2D !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd2 got %h want %h", rd2D, 32'hDEADBEEF); end
    rs2D = 5; #1;
    checks++; if (rd2D !== 32'h0000A5A5) begin errors++; $display("FAIL nobypass_rd2 got %h want %h", rd2D, 32'h0000A5A5); end
    rs2D = 7;
    @(posedge clk); #1;
    exp_cnt++;
    @(negedge clk);
    idle(); #1;
    checks++; if (rd1D !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_rd1 got %h want %h", rd1D, 32'hDEADBEEF); end
    checks++; if (rd2D !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_rd2 got %h want %h", rd2D, 32'hDEADBEEF); end
    checks++; if (wb_countW !== exp_cnt) begin errors++; $display("FAIL alu_cnt got %h want %h", wb_countW, exp_cnt); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle();
    reg_wrW = 1; rdW = 0; ALU_resultW = 32'hFFFFFFFF; rs1D = 0; rs2D = 0;
    #1;
    checks++; if (rd1D !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h want %h", rd1D, 32'h0); end
    @(posedge clk); #1;
    @(negedge clk);
    idle(); #1;
    checks++; if (rd1D !== 32'h0) begin errors++; $display("FAIL x0_read got %h want %h", rd1D, 32'h0); end
    checks++; if (wb_countW !== exp_cnt) begin errors++; $display("FAIL x0_cnt got %h want %h", wb_countW, exp_cnt); end
  endtask

  task automatic test_load();
    logic [2:0]  f3  [6];
    logic [1:0]  off [6];
    logic [31:0] exp [6];
    f3[0] = 3'b000; off[0] = 2'd3; exp[0] = 32'hFFFFFF80;
    f3[1] = 3'b100; off[1] = 2'd3; exp[1] = 32'h00000080;
    f3[2] = 3'b001; off[2] = 2'd2; exp[2] = 32'hFFFF80F1;
    f3[3] = 3'b101; off[3] = 2'd0; exp[3] = 32'h00007F02;
    f3[4] = 3'b010; off[4] = 2'd0; exp[4] = 32'h80F17F02;
    f3[5] = 3'b011; off[5] = 2'd0; exp[5] = 32'h00000000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      result_srcW = 2'b01; rd_dataW = 32'h80F17F02; funct3W = f3[i];
      ALU_resultW = {30'h40, off[i]};
      #1;
      checks++; if (resultW !== exp[i]) begin errors++; $display("FAIL load_%0d got %h want %h", i, resultW, exp[i]); end
      checks++; if (load_misalignW !== 1'b0) begin errors++; $display("FAIL load_mis_%0d got %b want 0", i, load_misalignW); end
    end
    // LH off=2 actually written to x10
    @(negedge clk);
    idle();
    reg_wrW = 1; rdW = 10; result_srcW = 2'b01; funct3W = 3'b001;
    rd_dataW = 32'h80F17F02; ALU_resultW = 32'h00000102; rs1D = 10;
    @(posedge clk); #1;
    exp_cnt++;
    @(negedge clk);
    idle(); #1;
    checks++; if (rd1D !== 32'hFFFF80F1) begin errors++; $display("FAIL load_wr_x10 got %h want %h", rd1D, 32'hFFFF80F1); end
    checks++; if (wb_countW !== exp_cnt) begin errors++; $display("FAIL load_cnt got %h want %h", wb_countW, exp_cnt); end
  endtask

  task automatic test_misalign();
    alu_write(9, 32'h00000055);
    exp_cnt++;
    reg_wrW = 1; rdW = 9; result_srcW = 2'b01; funct3W = 3'b010;
    rd_dataW = 32'hCAFEF00D; ALU_resultW = 32'h00000102; rs1D = 9;
    #1;
    checks++; if (load_misalignW !== 1'b1) begin errors++; $display("FAIL lw_misalign got %b want 1", load_misalignW); end
    checks++; if (rd1D !== 32'h00000055) begin errors++; $display("FAIL mis_nobypass got %h want %h", rd1D, 32'h00000055); end
    funct3W = 3'b101; ALU_resultW = 32'h00000103; #1;
    checks++; if (load_misalignW !== 1'b1) begin errors++; $display("FAIL lhu_misalign got %b want 1", load_misalignW); end
    funct3W = 3'b010; ALU_resultW = 32'h00000102;
    @(posedge clk); #1;
    @(negedge clk);
    idle(); #1;
    checks++; if (rd1D !== 32'h00000055) begin errors++; $display("FAIL x9_kept got %h want %h", rd1D, 32'h00000055); end
    checks++; if (wb_countW !== exp_cnt) begin errors++; $display("FAIL mis_cnt got %h want %h", wb_countW, exp_cnt); end
    ALU_resultW = 32'h00000102; funct3W = 3'b010; result_srcW = 2'b00; #1;
    checks++; if (load_misalignW !== 1'b0) begin errors++; $display("FAIL mis_nonload got %b want 0", load_misalignW); end
    idle();
  endtask

  task automatic test_jal_wrap();
    @(negedge clk);
    idle();
    reg_wrW = 1; rdW = 1; result_srcW = 2'b10; PCp4W = 32'h00000044;
    ALU_resultW = 32'h11111111; rs1D = 1; rs2D = 2;
    #1;
    checks++; if (resultW !== 32'h00000044) begin errors++; $display("FAIL jal_result got %h want %h", resultW, 32'h44); end
    @(posedge clk); #1;
    exp_cnt++;
    @(negedge clk);
    idle(); #1;
    checks++; if (rd1D !== 32'h00000044) begin errors++; $display("FAIL jal_x1 got %h want %h", rd1D, 32'h44); end
    result_srcW = 2'b11; ALU_resultW = 32'h12345678; PCp4W = 32'h9; #1;
    checks++; if (resultW !== 32'h0) begin errors++; $display("FAIL src11 got %h want %h", resultW, 32'h0); end
    idle();
    force dut.r_wb_count = 32'hFFFFFFFF;
    #1 release dut.r_wb_count;
    #1;
    checks++; if (wb_countW !== 32'hFFFFFFFF) begin errors++; $display("FAIL cnt_preload got %h want %h", wb_countW, 32'hFFFFFFFF); end
    reg_wrW = 1; rdW = 2; ALU_resultW = 32'h00000BEE;
    @(posedge clk); #1;
    @(negedge clk);
    idle(); #1;
    checks++; if (wb_countW !== 32'h0) begin errors++; $display("FAIL cnt_wrap got %h want %h", wb_countW, 32'h0); end
    checks++; if (rd2D !== 32'h00000BEE) begin errors++; $display("FAIL wrap_x2 got %h want %h", rd2D, 32'hBEE); end
  endtask

  initial begin
    rs1D = 0; rs2D = 0; exp_cnt = 0;
    test_reset();
    test_alu_bypass();
    test_x0();
    test_load();
    test_misalign();
    test_jal_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
